clk_div_prog: RTL

- Runtime-programmable integer clock divider, divide ratio N = 2..2^WIDTH-1.
- Output duty cycle is exactly 50% for both even and odd N. Odd N uses a negedge half-cycle extension flop.
- Sits in clock-generation logic as the generalised successor of the fixed divide-by-7 divider.
- Adds these behaviours: divisor changes are glitch-free and take effect only at a period boundary; an enable gates the output cleanly; a per-period tick is provided for synchronous logic.

---
 rtl/clk_div_prog_if.sv | 27 ++
 rtl/clk_div_prog.sv | 102 ++++++++++
 2 files changed

// File: rtl/clk_div_prog_if.sv
// Handshake/bus bundle for the programmable clock divider.
// The master drives enable and divisor; the slave returns the clock and status.
interface clk_div_prog_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic [WIDTH-1:0] div_val;
    logic             out_clk;
    logic             period_tick;
    logic [WIDTH-1:0] div_active;

    modport master (
        output en,
        output div_val,
        input  out_clk,
        input  period_tick,
        input  div_active
    );

    modport slave (
        input  en,
        input  div_val,
        output out_clk,
        output period_tick,
        output div_active
    );
endinterface

// File: rtl/clk_div_prog.sv
// Runtime-programmable 50% duty clock divider, N = 2..2^WIDTH-1.
// Divisor and enable are only acted on at a period boundary.
module clk_div_prog #(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 7
) (
    input  logic         clk,
    input  logic         rstn,
    clk_div_prog_if.slave bus
);

    localparam logic [WIDTH-1:0] DEF_N =
        (DEFAULT_DIV < 2) ? WIDTH'(2) : WIDTH'(DEFAULT_DIV);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_nxt;
    logic [WIDTH-1:0] div_q;
    logic [WIDTH-1:0] n_req;
    logic [WIDTH-1:0] half;
    logic [WIDTH-1:0] last;
    logic             boundary;
    logic             start;
    logic             pos_q;
    logic             neg_q;
    logic             odd_q;
    logic             tick_q;

    always_comb begin
        n_req    = (bus.div_val < WIDTH'(2)) ? WIDTH'(2) : bus.div_val;
        half     = div_q >> 1;
        last     = div_q - WIDTH'(1);
        cnt_nxt  = cnt + WIDTH'(1);
        boundary = (cnt == last);
        start    = bus.en & ((state == IDLE) | boundary);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= IDLE;
            cnt    <= '0;
            div_q  <= DEF_N;
            odd_q  <= DEF_N[0];
            pos_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    pos_q <= 1'b0;
                    cnt   <= '0;
                    if (start) begin
                        div_q  <= n_req;
                        odd_q  <= n_req[0];
                        pos_q  <= 1'b1;
                        tick_q <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    // pos_q and neg_q are both low here, so odd_q may switch
                    if (start) begin
                        div_q  <= n_req;
                        odd_q  <= n_req[0];
                        cnt    <= '0;
                        pos_q  <= 1'b1;
                        tick_q <= 1'b1;
                    end else if (boundary) begin
                        cnt   <= '0;
                        pos_q <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt   <= cnt_nxt;
                        pos_q <= (cnt_nxt < half);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Half-cycle extension of the high phase for odd divisors
    always_ff @(negedge clk or negedge rstn) begin
        if (!rstn) begin
            neg_q <= 1'b0;
        end else begin
            neg_q <= pos_q;
        end
    end

    assign bus.out_clk     = odd_q ? (pos_q | neg_q) : pos_q;
    assign bus.period_tick = tick_q;
    assign bus.div_active  = div_q;

endmodule
